// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/onehot_dec3_en.sv
// rtl/onehot_dec3_en.sv - combinational enabled 3-to-8 one-hot decode
module onehot_dec3_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter holding each grant until done or withdrawal
// Optional grant-length limit with a timeout pulse when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

`ifdef ARB_TIMEOUT_EN
  parameter int MAX_HOLD = MAX_HOLD_DEF;
`endif

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;

  // First set request at or above p, wrapping 7 -> 0; MSB flags that one was found.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] c;
    logic [IDX_W-1:0] sel;
    logic             found;
    found = 1'b0;
    sel   = p;
    for (int k = 0; k < N_REQ; k++) begin
      c = p + IDX_W'(k);
      if (!found && r[c]) begin
        found = 1'b1;
        sel   = c;
      end
    end
    return {found, sel};
  endfunction

  logic [IDX_W:0]   pick;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             release_hit;
  logic             rel_now;

  assign pick        = rr_pick(req, ptr);
  assign pick_found  = pick[IDX_W];
  assign pick_idx    = pick[IDX_W-1:0];
  assign release_hit = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign rel_now      = release_hit | hold_expired;
`else
  assign rel_now      = release_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (en && pick_found) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (rel_now) begin
            // Advance past the holder so it goes to the back of the rotation.
            ptr       <= gnt_idx + IDX_W'(1);
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout   <= ~release_hit;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  onehot_dec3_en u_dec (
    .idx (gnt_idx),
    .en  (gnt_valid),
    .y   (gnt_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8, with a timeout scenario under ARB_TIMEOUT_EN
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot),
    .busy(busy), .timeout(timeout)
  );
`else
  rr_arbiter8 dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot),
    .busy(busy)
  );
`endif

  // Scoreboard: every new grant must match the oldest expected index.
  always @(negedge clk) begin
    int e;
    logic [7:0] eo;
    if (gnt_valid && !prev_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_grant: got idx %0d, expected no grant", gnt_idx);
      end else begin
        e  = exp_q.pop_front();
        eo = 8'(1) << e;
        if (gnt_idx !== 3'(e) || gnt_onehot !== eo)
          $display("FAIL sb_grant: got idx %0d onehot %h, expected idx %0d onehot %h",
                   gnt_idx, gnt_onehot, e, eo);
        else
          passes++;
      end
    end
    prev_v = gnt_valid;
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", gnt_valid); else passes++;
    checks++;
    if (gnt_idx !== 3'd0) $display("FAIL reset_idx: got %0d, expected 0", gnt_idx); else passes++;
    checks++;
    if (gnt_onehot !== 8'h00) $display("FAIL reset_onehot: got %h, expected 00", gnt_onehot); else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_no_req();
    en = 1'b1; req = 8'h00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_valid, gnt_onehot} !== 9'h000)
        $display("FAIL no_req_idle: got valid %b onehot %h, expected 0 00", gnt_valid, gnt_onehot);
      else
        passes++;
    end
  endtask

  task automatic test_alternate();
    int idle;
    bit seen;
    do_reset();
    en = 1'b1; req = 8'h24;
    exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(5);
    for (int g = 0; g < 4; g++) begin
      idle = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        done = 1'b0;
        if (gnt_valid) seen = 1'b1;
        else idle++;
      end
      checks++;
      if (!seen) begin
        $display("FAIL alt_wait: got no grant within 20 cycles, expected grant %0d", g);
      end else begin
        passes++;
        if (g > 0) begin
          checks++;
          if (idle !== 1) $display("FAIL alt_gap: got %0d idle cycles, expected 1", idle); else passes++;
        end
      end
      @(negedge clk);
      done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0; req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    en = 1'b1; req = 8'h80;
    exp_q.push_back(7); exp_q.push_back(0);
    wait_grant(ok);
    checks++;
    if (!ok) $display("FAIL wrap_first: got no grant, expected idx 7"); else passes++;
    req = 8'h81;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0) $display("FAIL wrap_release: got valid %b, expected 0", gnt_valid); else passes++;
    wait_grant(ok);
    checks++;
    if (!ok || gnt_onehot !== 8'h01)
      $display("FAIL wrap_next: got valid %b onehot %h, expected 1 01", gnt_valid, gnt_onehot);
    else
      passes++;
    done = 1'b1; req = 8'h00;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdraw_en();
    bit ok;
    do_reset();
    en = 1'b1; req = 8'h08;
    exp_q.push_back(3); exp_q.push_back(4);
    wait_grant(ok);
    checks++;
    if (!ok) $display("FAIL wd_first: got no grant, expected idx 3"); else passes++;
    req = 8'h00;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0) $display("FAIL wd_release: got valid %b, expected 0", gnt_valid); else passes++;
    req = 8'h19;
    wait_grant(ok);
    checks++;
    if (!ok || gnt_idx !== 3'd4)
      $display("FAIL wd_ptr: got valid %b idx %0d, expected 1 4", gnt_valid, gnt_idx);
    else
      passes++;
    done = 1'b1; en = 1'b0;
    @(negedge clk);
    done = 1'b0; req = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b0) $display("FAIL en_block: got valid %b, expected 0", gnt_valid); else passes++;
    end
    req = 8'h00; en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    bit ok;
    do_reset();
    en = 1'b1; req = 8'h40;
    exp_q.push_back(6); exp_q.push_back(6); exp_q.push_back(0);
    wait_grant(ok);
    checks++;
    if (!ok) $display("FAIL rst_first: got no grant, expected idx 6"); else passes++;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok) $display("FAIL rst_second: got no grant, expected idx 6"); else passes++;
    @(negedge clk);
    rst = 1'b1; req = 8'hFF;
    @(negedge clk);
    checks++;
    if ({gnt_valid, gnt_onehot, busy} !== 10'h000)
      $display("FAIL rst_clear: got valid %b onehot %h busy %b, expected 0 00 0",
               gnt_valid, gnt_onehot, busy);
    else
      passes++;
    rst = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok || gnt_idx !== 3'd0)
      $display("FAIL rst_ptr: got valid %b idx %0d, expected 1 0", gnt_valid, gnt_idx);
    else
      passes++;
    done = 1'b1; req = 8'h00;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int hi;
    do_reset();
    en = 1'b1; req = 8'h02;
    exp_q.push_back(1); exp_q.push_back(1);
    wait_grant(ok);
    hi = ok ? 1 : 0;
    for (int c = 0; c < 20 && ok; c++) begin
      @(negedge clk);
      if (gnt_valid) hi++;
      else break;
    end
    checks++;
    if (hi !== 4) $display("FAIL to_hold: got %0d grant cycles, expected 4", hi); else passes++;
    checks++;
    if (timeout !== 1'b1) $display("FAIL to_pulse: got timeout %b, expected 1", timeout); else passes++;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || timeout !== 1'b0)
      $display("FAIL to_regrant: got valid %b timeout %b, expected 1 0", gnt_valid, timeout);
    else
      passes++;
    req = 8'h00;
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    test_reset();
    test_no_req();
    test_alternate();
    test_wrap();
    test_withdraw_en();
    test_rst_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() !== 0)
      $display("FAIL sb_drain: got %0d grants still expected, expected 0", exp_q.size());
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
